// File: rtl/adc_tx_pkg.sv
// rtl/adc_tx_pkg.sv - shared widths, mode encodings and defaults for the ADC emulator transmitter
package adc_tx_pkg;

    localparam int LANE_W      = 6;
    localparam int SAMPLE_W    = 12;
    localparam int NCH_DEFAULT = 4;
    localparam int MAX_SKEW    = 5;
    localparam int RAMP_STEP   = 1024;

    localparam logic [LANE_W-1:0] FRAME_DEFAULT = 6'b111000;

    typedef enum logic [1:0] {
        MODE_DATA    = 2'd0,
        MODE_RAMP    = 2'd1,
        MODE_PATTERN = 2'd2,
        MODE_ALT     = 2'd3
    } tx_mode_e;

    // Skew codes above the delay-line depth saturate at the deepest tap.
    function automatic logic [2:0] clamp_skew(input logic [2:0] s);
        return (s > 3'(MAX_SKEW)) ? 3'(MAX_SKEW) : s;
    endfunction

endpackage

// File: rtl/adc_lane_ser.sv
// rtl/adc_lane_ser.sv - one serial lane: 6-bit load/shift register feeding a tapped skew delay line
module adc_lane_ser
    import adc_tx_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              enable,
    input  logic              load,
    input  logic [LANE_W-1:0] load_data,
    input  logic [2:0]        skew,
    output logic              dout
);

    logic [LANE_W-1:0]   shift_q;
    logic [MAX_SKEW-1:0] delay_q;
    logic [7:0]          taps;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shift_q <= '0;
            delay_q <= '0;
        end else if (!enable) begin
            shift_q <= '0;
            delay_q <= '0;
        end else begin
            delay_q <= {delay_q[MAX_SKEW-2:0], shift_q[LANE_W-1]};
            if (load) begin
                shift_q <= load_data;
            end else begin
                shift_q <= {shift_q[LANE_W-2:0], 1'b0};
            end
        end
    end

    // Tap 0 is the undelayed MSB; tap n is the same stream n cycles later.
    assign taps = {{(7 - MAX_SKEW){1'b0}}, delay_q, shift_q[LANE_W-1]};
    assign dout = enable & taps[skew];

endmodule

// File: rtl/adc_emul_tx.sv
// rtl/adc_emul_tx.sv - ADC emulator transmitter: per-frame word generation and serial lane fan-out
module adc_emul_tx
    import adc_tx_pkg::*;
#(
    parameter logic [LANE_W-1:0] FRAME = FRAME_DEFAULT,
    parameter int                NCH   = NCH_DEFAULT
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    ENABLE,
    input  logic [1:0]              MODE,
    input  logic [SAMPLE_W-1:0]     PATTERN,
    input  logic [2:0]              SKEW,
    input  logic [SAMPLE_W*NCH-1:0] DIN,
    input  logic                    DIN_VALID,
    output logic                    DIN_READY,
    output logic [2*NCH-1:0]        DOUT,
    output logic                    FR,
    input  logic                    CLR_UNDERRUN,
    output logic                    UNDERRUN
);

    logic [2:0]          bit_k;
    logic                load;
    tx_mode_e            mode_in;
    logic [2:0]          skew_q;
    logic [SAMPLE_W-1:0] ramp_q;
    logic                alt_q;
    logic [SAMPLE_W-1:0] last_q [NCH];
    logic [SAMPLE_W-1:0] word   [NCH];
    logic                xfer;
    logic                underrun_set;

    assign mode_in      = tx_mode_e'(MODE);
    assign load         = ENABLE && (bit_k == 3'd5);
    // The handshake follows the mode that this load point is about to sample.
    assign DIN_READY    = RST_N && load && (mode_in == MODE_DATA);
    assign xfer         = DIN_READY && DIN_VALID;
    assign underrun_set = load && (mode_in == MODE_DATA) && !DIN_VALID;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            word[c] = last_q[c];
            case (mode_in)
                MODE_DATA:    if (xfer) word[c] = DIN[SAMPLE_W*c +: SAMPLE_W];
                MODE_RAMP:    word[c] = ramp_q + SAMPLE_W'(c * RAMP_STEP);
                MODE_PATTERN: word[c] = PATTERN;
                MODE_ALT:     word[c] = alt_q ? ~PATTERN : PATTERN;
                default:      word[c] = last_q[c];
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bit_k    <= 3'd5;
            skew_q   <= '0;
            ramp_q   <= '0;
            alt_q    <= 1'b0;
            UNDERRUN <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                last_q[c] <= '0;
            end
        end else begin
            if (!ENABLE) begin
                bit_k <= 3'd5;
            end else if (load) begin
                bit_k <= 3'd0;
            end else begin
                bit_k <= bit_k + 3'd1;
            end

            if (load) begin
                skew_q <= clamp_skew(SKEW);
                if (mode_in == MODE_RAMP) ramp_q <= ramp_q + 1'b1;
                if (mode_in == MODE_ALT)  alt_q  <= ~alt_q;
                // Only DATA frames refresh the word replayed on underrun.
                if (mode_in == MODE_DATA) begin
                    for (int c = 0; c < NCH; c++) begin
                        last_q[c] <= word[c];
                    end
                end
            end

            if (underrun_set) begin
                UNDERRUN <= 1'b1;
            end else if (CLR_UNDERRUN) begin
                UNDERRUN <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < 2*NCH; g++) begin : g_lane
        logic [LANE_W-1:0] half;
        if (g % 2 == 0) begin : g_hi
            assign half = word[g/2][SAMPLE_W-1:LANE_W];
        end else begin : g_lo
            assign half = word[g/2][LANE_W-1:0];
        end
        adc_lane_ser u_ser (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .enable    (ENABLE),
            .load      (load),
            .load_data (half),
            .skew      (skew_q),
            .dout      (DOUT[g])
        );
    end

    adc_lane_ser u_fr (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .enable    (ENABLE),
        .load      (load),
        .load_data (FRAME),
        .skew      (skew_q),
        .dout      (FR)
    );

endmodule

// File: tb/tb_adc_emul_tx.sv
// tb/tb_adc_emul_tx.sv - randomized self-checking bench for adc_emul_tx against a frame-level model
module tb_adc_emul_tx;
    import adc_tx_pkg::*;

    localparam int NCH = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        ENABLE = 1'b0;
    logic [1:0]  MODE = 2'd0;
    logic [11:0] PATTERN = 12'd0;
    logic [2:0]  SKEW = 3'd0;
    logic [47:0] DIN = 48'd0;
    logic        DIN_VALID = 1'b0;
    logic        DIN_READY;
    logic [7:0]  DOUT;
    logic        FR;
    logic        CLR_UNDERRUN = 1'b0;
    logic        UNDERRUN;

    always #5 CLK = ~CLK;

    adc_emul_tx #(.FRAME(6'b111000), .NCH(NCH)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .ENABLE       (ENABLE),
        .MODE         (MODE),
        .PATTERN      (PATTERN),
        .SKEW         (SKEW),
        .DIN          (DIN),
        .DIN_VALID    (DIN_VALID),
        .DIN_READY    (DIN_READY),
        .DOUT         (DOUT),
        .FR           (FR),
        .CLR_UNDERRUN (CLR_UNDERRUN),
        .UNDERRUN     (UNDERRUN)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: words chosen per frame, bits indexed by position, output = history[skew].
    logic [5:0]  frame_pat = 6'b111000;
    int          mk = 5;
    int          m_skew = 0;
    int          m_r = 0;
    int          m_fmode = 0;
    bit          m_alt = 0;
    bit          m_under = 0;
    logic [11:0] m_last [NCH];
    logic [11:0] m_word [NCH];
    logic [8:0]  hist [6];
    logic [5:0]  cap [9];
    logic        obs_ready;

    function automatic logic [47:0] rand48();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[47:0];
    endfunction

    task automatic model_reset();
        mk = 5; m_skew = 0; m_r = 0; m_alt = 0; m_under = 0;
        for (int c = 0; c < NCH; c++) begin
            m_last[c] = 12'd0;
            m_word[c] = 12'd0;
        end
        for (int i = 0; i < 6; i++) hist[i] = 9'd0;
    endtask

    task automatic model_edge();
        bit         set;
        logic [8:0] raw;
        set = 0;
        if (!RST_N) begin
            model_reset();
            return;
        end
        if (ENABLE) begin
            if (mk == 5) begin
                m_skew  = (SKEW > 3'd5) ? 5 : int'(SKEW);
                m_fmode = int'(MODE);
                for (int c = 0; c < NCH; c++) begin
                    case (MODE)
                        2'd0: begin
                            if (DIN_VALID) m_last[c] = DIN[12*c +: 12];
                            m_word[c] = m_last[c];
                        end
                        2'd1:    m_word[c] = 12'((m_r + 1024*c) % 4096);
                        2'd2:    m_word[c] = PATTERN;
                        default: m_word[c] = m_alt ? ~PATTERN : PATTERN;
                    endcase
                end
                if (MODE == 2'd0 && !DIN_VALID) set = 1;
                if (MODE == 2'd1) m_r = (m_r + 1) % 4096;
                if (MODE == 2'd3) m_alt = !m_alt;
                mk = 0;
            end else begin
                mk++;
            end
            for (int c = 0; c < NCH; c++) begin
                raw[2*c]   = m_word[c][11-mk];
                raw[2*c+1] = m_word[c][5-mk];
            end
            raw[8] = frame_pat[5-mk];
            for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = raw;
        end else begin
            mk = 5;
            for (int i = 0; i < 6; i++) hist[i] = 9'd0;
        end
        if (set) m_under = 1;
        else if (CLR_UNDERRUN) m_under = 0;
    endtask

    task automatic cyc();
        logic [8:0] exp;
        #1;
        obs_ready = DIN_READY;
        check_eq("din_ready", 32'(DIN_READY), 32'(RST_N && ENABLE && mk == 5 && MODE == 2'd0));
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        exp = ENABLE ? hist[m_skew] : 9'd0;
        check_eq("dout", 32'(DOUT), 32'(exp[7:0]));
        check_eq("fr", 32'(FR), 32'(exp[8]));
        check_eq("underrun", 32'(UNDERRUN), 32'(m_under));
        for (int i = 0; i < 8; i++) cap[i] = {cap[i][4:0], DOUT[i]};
        cap[8] = {cap[8][4:0], FR};
    endtask

    task automatic align_k5();
        for (int i = 0; i < 6 && mk != 5; i++) cyc();
    endtask

    initial begin
        int          ready_cnt;
        int          wraps;
        logic [11:0] w;
        logic [11:0] prev;

        model_reset();
        for (int i = 0; i < 9; i++) cap[i] = 6'd0;
        ENABLE = 1'b1;
        DIN_VALID = 1'b1;
        repeat (2) @(negedge CLK);
        check_eq("rst_dout", 32'(DOUT), 32'd0);
        check_eq("rst_fr", 32'(FR), 32'd0);
        check_eq("rst_ready", 32'(DIN_READY), 32'd0);
        check_eq("rst_underrun", 32'(UNDERRUN), 32'd0);

        // DATA mode, skew 0, channel 0 fixed to A5C
        RST_N = 1'b1;
        DIN = rand48();
        DIN[11:0] = 12'hA5C;
        ready_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (obs_ready) ready_cnt++;
            if (i == 5) begin
                check_eq("a5c_lane0", 32'(cap[0]), 32'(6'b101001));
                check_eq("a5c_lane1", 32'(cap[1]), 32'(6'b011100));
                check_eq("a5c_fr", 32'(cap[8]), 32'(6'b111000));
            end
        end
        check_eq("ready_duty", 32'(ready_cnt), 32'd5);

        // DATA mode with random valid drops and clears
        for (int i = 0; i < 120; i++) begin
            DIN_VALID = ($urandom_range(0, 3) != 0);
            DIN = rand48();
            CLR_UNDERRUN = ($urandom_range(0, 9) == 0);
            cyc();
        end
        CLR_UNDERRUN = 1'b1;
        DIN_VALID = 1'b1;
        cyc();
        align_k5();
        CLR_UNDERRUN = 1'b0;
        check_eq("underrun_clean", 32'(UNDERRUN), 32'd0);
        DIN_VALID = 1'b0;
        cyc();
        check_eq("underrun_set", 32'(UNDERRUN), 32'd1);
        DIN_VALID = 1'b1;
        repeat (12) cyc();
        check_eq("underrun_sticky", 32'(UNDERRUN), 32'd1);
        CLR_UNDERRUN = 1'b1;
        cyc();
        CLR_UNDERRUN = 1'b0;
        check_eq("underrun_clr", 32'(UNDERRUN), 32'd0);

        // RAMP across a full wrap of channel 3
        align_k5();
        MODE = 2'd1;
        DIN_VALID = 1'b0;
        wraps = 0;
        prev = 12'd0;
        for (int f = 0; f < 4097; f++) begin
            repeat (6) cyc();
            w = {cap[6], cap[7]};
            if (f == 0) check_eq("ramp_first", 32'(w), 32'd3072);
            if (f > 0 && prev == 12'd4095 && w == 12'd0) wraps++;
            prev = w;
        end
        check_eq("ramp_wraps", 32'(wraps), 32'd1);
        check_eq("ramp_last", 32'(prev), 32'd3072);

        // PATTERN then ALTERNATE with FC0
        MODE = 2'd2;
        PATTERN = 12'($urandom);
        repeat (18) cyc();
        MODE = 2'd3;
        PATTERN = 12'hFC0;
        for (int f = 0; f < 4; f++) begin
            repeat (6) cyc();
            check_eq("alt_lane0", 32'(cap[0]), (f % 2 == 0) ? 32'h3F : 32'h0);
            check_eq("alt_lane1", 32'(cap[1]), (f % 2 == 0) ? 32'h0 : 32'h3F);
        end

        // SKEW stepped 0 -> 3 mid-frame, takes effect at the next load point
        MODE = 2'd2;
        repeat (3) cyc();
        SKEW = 3'd3;
        repeat (3) cyc();
        repeat (6) cyc();
        check_eq("fr_skew3", 32'(cap[8]), 32'(6'b000111));
        SKEW = 3'd7;
        repeat (12) cyc();

        // Randomized run with enable toggles and mode/skew changes
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) ENABLE = ~ENABLE;
            if ($urandom_range(0, 29) == 0) MODE = 2'($urandom);
            if ($urandom_range(0, 24) == 0) SKEW = 3'($urandom);
            if ($urandom_range(0, 49) == 0) PATTERN = 12'($urandom);
            DIN_VALID = ($urandom_range(0, 4) != 0);
            DIN = rand48();
            CLR_UNDERRUN = ($urandom_range(0, 19) == 0);
            cyc();
        end

        // Reset asserted mid-frame at k=2
        ENABLE = 1'b1;
        MODE = 2'd0;
        SKEW = 3'd0;
        DIN_VALID = 1'b0;
        CLR_UNDERRUN = 1'b0;
        for (int i = 0; i < 14 && !(mk == 2 && m_skew == 0 && m_under); i++) cyc();
        check_eq("pre_rst_k", 32'(mk), 32'd2);
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        check_eq("mid_rst_dout", 32'(DOUT), 32'd0);
        check_eq("mid_rst_fr", 32'(FR), 32'd0);
        check_eq("mid_rst_underrun", 32'(UNDERRUN), 32'd0);
        check_eq("mid_rst_ready", 32'(DIN_READY), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        DIN_VALID = 1'b1;
        DIN = rand48();
        DIN[11:0] = 12'hA5C;
        repeat (6) cyc();
        check_eq("restart_lane0", 32'(cap[0]), 32'(6'b101001));
        check_eq("restart_fr", 32'(cap[8]), 32'(6'b111000));
        repeat (12) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_emul_tx.md
ADC_EMUL_TX -- requirements
Module: adc_emul_tx

Interface
REQ-001 SHALL have parameter FRAME, default 6'b111000: frame pattern, MSB sent first.
REQ-002 SHALL have parameter NCH, default 4: number of channels, each 12 bits on 2 lanes.
REQ-003 SHALL have port CLK, input, 1: single clock; one serial bit per lane per CLK cycle.
REQ-004 SHALL have port RST_N, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ENABLE, input, 1: high runs the serializer; low idles it.
REQ-006 SHALL have port MODE, input, 2: 0 DATA, 1 RAMP, 2 PATTERN, 3 ALTERNATE.
REQ-007 SHALL have port PATTERN, input, 12: fixed word for MODE 2 and MODE 3.
REQ-008 SHALL have port SKEW, input, 3: stream delay in bit times, valid 0..5; values 6 and 7 treated as 5.
REQ-009 SHALL have port DIN, input, 48: channel c occupies bits [12c+11:12c].
REQ-010 SHALL have port DIN_VALID, input, 1: DIN holds a valid sample set.
REQ-011 SHALL have port DIN_READY, output, 1: transmitter accepts DIN this cycle.
REQ-012 SHALL have port DOUT, output, 8: serial lanes; lane 2c carries channel c bits [11:6], lane 2c+1 carries bits [5:0].
REQ-013 SHALL have port FR, output, 1: serial frame lane.
REQ-014 SHALL have port CLR_UNDERRUN, input, 1: clears UNDERRUN.
REQ-015 SHALL have port UNDERRUN, output, 1: sticky flag, DATA mode had no word at a load point.

Function
REQ-016 SHALL keep bit counter k, cycling 0..5 while ENABLE=1 and held at 5 while ENABLE=0.
REQ-017 SHALL load all lane shifters and the frame shifter on the CLK edge ending each k=5 cycle ("load point").
REQ-018 SHALL present, at k=0..5 before delay, bit (5-k) of each 6-bit half-word and FRAME[5-k], MSB first.
REQ-019 SHALL, in DATA mode, assert DIN_READY exactly in k=5 cycles with ENABLE=1; transfer = DIN_VALID and DIN_READY.
REQ-020 SHALL, at a DATA load point with no transfer, retransmit the previous word and set UNDERRUN.
REQ-021 SHALL, in RAMP mode, send channel c value (R + 1024c) mod 4096, with 12-bit R incrementing by 1 per frame and wrapping 4095 to 0.
REQ-022 SHALL, in PATTERN mode, send PATTERN on all channels every frame.
REQ-023 SHALL, in ALTERNATE mode, send PATTERN and ~PATTERN on alternate frames, starting with PATTERN.
REQ-024 SHALL keep DIN_READY=0 in modes 1-3.
REQ-025 SHALL sample MODE and PATTERN only at load points.
REQ-026 SHALL delay DOUT and FR together by SKEW cycles through a 6-deep delay line. With SKEW=0, the first bit of a frame appears on the cycle after its load point.
REQ-027 SHALL sample SKEW only at load points; bits already in the delay line are not re-timed.
REQ-028 SHALL, with ENABLE=0, drive DOUT=0 and FR=0 and flush the delay line to 0.
REQ-029 SHALL, on ENABLE rising, treat the first edge as a load point, so the first frame starts the next cycle.
REQ-030 SHALL give set priority over clear when CLR_UNDERRUN and an underrun occur in the same cycle.

Reset
REQ-031 SHALL, while RST_N=0, force DOUT=0, FR=0, DIN_READY=0, UNDERRUN=0, k=5, R=0, shifters, delay line and last-word registers to 0, and the alternate phase to PATTERN.
REQ-032 SHALL start the first frame at the first load point after RST_N release with ENABLE=1; reset mid-frame discards the frame.

Structure
REQ-033 SHALL take FRAME default, MODE encodings, lane and sample widths from shared package adc_tx_pkg.
REQ-034 SHALL use sub-module adc_lane_ser (6-bit load/shift register plus SKEW delay line), instantiated 8 times for DOUT and once for FR.

Verification
REQ-035 SHALL cover: MODE 0, SKEW 0, channel 0 = 12'hA5C -> lane0 101001, lane1 011100, FR 111000, aligned; DIN_READY high 1 of 6 cycles.
REQ-036 SHALL cover: MODE 0, DIN_VALID dropped for one load point -> previous word repeated, UNDERRUN=1 until CLR_UNDERRUN.
REQ-037 SHALL cover: MODE 1 over 4097 frames -> channel 3 sequence starts 3072 and wraps 4095 to 0 once.
REQ-038 SHALL cover: MODE 3, PATTERN 12'hFC0 -> lane0 alternates 111111/000000 per frame; lane1 alternates 000000/111111.
REQ-039 SHALL cover: SKEW stepped 0 to 3 mid-run -> FR becomes 111000 delayed 3 cycles from the next frame onward; adc4rcv-compatible receiver relocks after bitslip.
REQ-040 SHALL cover: RST_N asserted at k=2 -> all outputs 0 immediately; first frame restarts cleanly after release.
